mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported fixed-latency memory between the fetch stage (read-only,
//  word) and the data stage (load/store). Data has priority; a starvation counter
//  forces a fetch grant. Returns each response to its owner and drives the per-stage
//  stall lines, including the fetch-stage IF_stall. One transaction in flight at a time.
// PARAMETERS
//  MEM_LAT     1   memory read latency in cycles, legal 1..15
//  STARVE_MAX  4   consecutive fetch-loss cycles before fetch is forced, legal 1..15
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous, active-low reset
//  if_req    in   1   fetch request, held until if_rvalid
//  if_addr   in   32  fetch address, stable while if_req
//  flush     in   1   branch redirect: discard in-flight/pending fetch response
//  halt      in   1   stop issuing new fetch grants
//  if_gnt    out  1   fetch granted this cycle
//  if_rvalid out  1   fetch response valid (1-cycle pulse)
//  if_rdata  out  32  instruction word
//  if_stall  out  1   to fetch stage IF_stall
//  d_req     in   1   data request, held until d_rvalid
//  d_we      in   1   1 = store
//  d_size    in   2   access size, `SIZE_* encoding
//  d_addr    in   32  data address
//  d_wdata   in   32  store data
//  d_gnt     out  1   data granted this cycle
//  d_rvalid  out  1   data completion (load or store), 1-cycle pulse
//  d_rdata   out  32  load data; 0 for stores
//  d_stall   out  1   data-stage stall
//  m_req     out  1   memory request
//  m_we      out  1   memory write enable
//  m_size    out  2   memory access size
//  m_addr    out  32  memory address
//  m_wdata   out  32  memory write data
//  m_rdata   in   32  memory read data, valid MEM_LAT cycles after m_req
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, owner=none, lat_cnt=0, starve_cnt=0; all outputs
//    0. Any in-flight transaction is dropped; no rvalid after reset release.
//  - FSM IDLE/BUSY. Port is "free" in IDLE, or in BUSY on the response cycle.
//  - Grant (combinational, when free): fetch eligible = if_req & ~halt.
//    Fetch wins if eligible & (~d_req | starve_cnt==STARVE_MAX); else data wins if d_req.
//  - Grant cycle N: gnt=1, m_req=1, m_* from winner (fetch: m_we=0, m_size=`SIZE_WORD);
//    owner and lat_cnt=MEM_LAT latched; state->BUSY.
//  - Response at cycle N+MEM_LAT: owner rvalid=1, rdata=m_rdata (d_rdata=0 if store).
//    Same cycle is free: new grant allowed, giving one transaction per MEM_LAT cycles.
//    No new grant -> IDLE.
//  - Non-grant cycles: m_req=m_we=0, m_addr=m_wdata=0, m_size=0.
//  - starve_cnt: +1 (saturating) each cycle fetch is eligible and not granted; cleared
//    on fetch grant or when fetch not eligible.
//  - if_stall = if_req & ~if_rvalid; d_stall = d_req & ~d_rvalid (combinational).
//  - flush: in a cycle with fetch in flight or on its response cycle, if_rvalid is
//    suppressed; memory access still completes and holds the port. Flush never affects
//    data. A fetch grant in a flush cycle proceeds (new address).
//  - halt: blocks new fetch grants only; in-flight fetch completes; data still served.
//  - Simultaneous response and re-grant to the same requester is legal
//    (rvalid and gnt both 1).
// STRUCTURE
//  - Shared defines: `SIZE_* encodings (existing header); add OWN_NONE/OWN_IF/OWN_D
//    and ARB_IDLE/ARB_BUSY localparams to the shared package.
//  - One sub-module: mem_lat_timer (load MEM_LAT, count down, flag done).
//    Priority/starvation logic stays inline.
// TESTING
//  - Reset: rst=0 mid-BUSY -> all outputs 0 immediately; no rvalid after release.
//  - Fetch only, MEM_LAT=2: if_req@0x100 at cycle 0 -> if_gnt c0,
//    if_rvalid c2 with m_rdata; re-grant 0x104 at c2.
//  - Contention: if_req, d_req both held, STARVE_MAX=4, MEM_LAT=1 -> data granted
//    c0..c3, fetch forced c4, starve_cnt 0 at c5.
//  - Store: d_we=1, d_size=`SIZE_WORD, 0x200<-0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF,
//    d_rvalid after MEM_LAT, d_rdata=0.
//  - Flush: fetch granted c0, MEM_LAT=3, flush at c2 -> no if_rvalid at c3,
//    port free at c3.
//  - Halt: halt=1 with if_req held -> no if_gnt, if_stall=1; d_req still granted.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared constants and types for the memory-port arbiter:
//   - SIZE_* access-size encodings for the memory interface
//   - owner_e  : which stage owns the transaction in flight
//   - arb_state_e : arbiter FSM states
//   - arb_dbg_t : debug view of the arbiter's internal state
package mem_port_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        arb_state_e state;
        owner_e     owner;
        logic [3:0] starve_cnt;
        logic       if_killed;
    } arb_dbg_t;

endpackage

// File: rtl/mem_port_arbiter_mem_lat_timer.sv
// mem_lat_timer
//   Fixed-latency response timer. Loading starts a countdown of MEM_LAT
//   cycles; done is high on the cycle the memory response is due
//   (MEM_LAT cycles after the load cycle).
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  asynchronous active-low reset
//     load  in  start a new countdown (grant cycle)
//     done  out response cycle of the most recent load
module mem_lat_timer #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    logic [3:0] cnt_q, cnt_d;

    // A load on the done cycle restarts the count, allowing back-to-back
    // transactions every MEM_LAT cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 4'(MEM_LAT);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported fixed-latency memory between the fetch stage
//   (read-only words) and the data stage (loads/stores). Data has priority
//   unless fetch has lost STARVE_MAX consecutive cycles. One transaction is
//   in flight at a time; the port is free again on the response cycle.
//   Ports:
//     clk, rst                 clock, async active-low reset
//     if_req/if_addr           fetch request and address
//     flush, halt              drop pending fetch response / block fetch grants
//     if_gnt/if_rvalid/if_rdata/if_stall   fetch-side results
//     d_req/d_we/d_size/d_addr/d_wdata     data request
//     d_gnt/d_rvalid/d_rdata/d_stall       data-side results
//     m_req/m_we/m_size/m_addr/m_wdata     memory request (grant cycle only)
//     m_rdata                  memory read data, valid MEM_LAT cycles after m_req
//     dbg                      internal state view
//
//   Handshake: a requester holds req (and its address/data) until it sees
//   rvalid. gnt pulses on the cycle the request reaches memory; rvalid pulses
//   MEM_LAT cycles later. A requester may be re-granted on its rvalid cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        flush,
    input  logic        halt,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        m_req,
    output logic        m_we,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output arb_dbg_t    dbg
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       store_q, store_d;
    logic       kill_q, kill_d;
    logic [3:0] starve_q, starve_d;

    logic lat_done, resp, free, if_elig, starved, if_win, d_win, grant;

    mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (grant),
        .done (lat_done)
    );

    assign resp    = (state_q == ARB_BUSY) & lat_done;
    assign free    = (state_q == ARB_IDLE) | resp;
    assign if_elig = if_req & ~halt;
    assign starved = (starve_q == 4'(STARVE_MAX));

    // Outputs are gated by rst so that everything reads 0 while reset is held.
    assign if_win = rst & free & if_elig & (~d_req | starved);
    assign d_win  = rst & free & ~if_win & d_req;
    assign grant  = if_win | d_win;

    always_comb begin
        if_gnt  = if_win;
        d_gnt   = d_win;
        m_req   = grant;
        m_we    = 1'b0;
        m_size  = 2'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        if (if_win) begin
            m_size = SIZE_WORD;
            m_addr = if_addr;
        end else if (d_win) begin
            m_we    = d_we;
            m_size  = d_size;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Flush in the response cycle itself also kills the fetch response.
    assign if_rvalid = rst & resp & (owner_q == OWN_IF) & ~kill_q & ~flush;
    assign d_rvalid  = rst & resp & (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? m_rdata : 32'd0;
    assign d_rdata   = (d_rvalid & ~store_q) ? m_rdata : 32'd0;
    assign if_stall  = rst & if_req & ~if_rvalid;
    assign d_stall   = rst & d_req & ~d_rvalid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        store_d = store_q;
        kill_d  = kill_q;
        if (grant) begin
            state_d = ARB_BUSY;
            owner_d = if_win ? OWN_IF : OWN_D;
            store_d = d_win & d_we;
            kill_d  = 1'b0;
        end else if (resp) begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
            store_d = 1'b0;
            kill_d  = 1'b0;
        end else if ((state_q == ARB_BUSY) && (owner_q == OWN_IF) && flush) begin
            // Remember the flush so the late response is still dropped.
            kill_d = 1'b1;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (if_elig && !if_win) begin
            starve_d = starved ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_NONE;
            store_q  <= 1'b0;
            kill_q   <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            store_q  <= store_d;
            kill_q   <= kill_d;
            starve_q <= starve_d;
        end
    end

    assign dbg = '{state: state_q, owner: owner_q, starve_cnt: starve_q, if_killed: kill_q};

endmodule
